// File: rtl/sdram_host_bridge_pkg.sv
// Shared constants and enums for the UART/SPI-to-SDRAM host bridge.
package host_bridge_pkg;

    localparam logic [7:0] OP_VERSION = 8'h30;
    localparam logic [7:0] OP_READ    = 8'h31;
    localparam logic [7:0] OP_WRITE   = 8'h32;
    localparam logic [7:0] OP_FILL    = 8'h33;

    localparam logic [7:0] ACK_OK      = 8'h01;
    localparam logic [7:0] ACK_OVERRUN = 8'hEE;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_ACT   = 2'b11
    } sdram_cmd_e;

    typedef enum logic [1:0] {
        XFER_VER,
        XFER_READ,
        XFER_WRITE,
        XFER_FILL
    } xfer_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD_ACT,
        ST_RD_CMD,
        ST_RD_SEND,
        ST_WR_COLLECT,
        ST_WR_ACT,
        ST_WR_CMD,
        ST_FILL_ACT,
        ST_FILL_CMD,
        ST_ACK,
        ST_SPI_ACT,
        ST_SPI_CMD
    } state_e;

endpackage

// File: rtl/sdram_host_bridge_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, with a registered rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/sdram_host_bridge.sv
// UART command bridge to an SDRAM controller, with an SPI-requested erase path.
module sdram_host_bridge
    import host_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned BEAT_BYTES = 8,
    parameter logic [7:0]  VERSION    = 8'h02
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rxd_strobe,
    input  logic [7:0]              rxd_data,
    input  logic                    txd_ready,
    output logic                    txd_strobe,
    output logic [7:0]              txd_data,
    output logic [1:0]              sdram_cmd,
    output logic [ADDR_W+1:0]       sdram_addr,
    input  logic                    sdram_cmd_busy,
    input  logic [BEAT_BYTES*8-1:0] sdram_rdata,
    output logic [BEAT_BYTES*8-1:0] sdram_wdata,
    output logic [BEAT_BYTES-1:0]   sdram_wmask,
    input  logic                    spi_active,
    input  logic                    spi_req,
    input  logic [ADDR_W-1:0]       spi_addr,
    input  logic [LEN_W-1:0]        spi_len,
    output logic                    spi_done
);

    localparam int unsigned DATA_W = BEAT_BYTES * 8;
    localparam int unsigned IDX_W  = $clog2(BEAT_BYTES);
    localparam int unsigned ABYTES = (ADDR_W + 7) / 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_BYTES - 1);

    state_e                r_state, w_state_nxt;
    xfer_e                 r_xfer, w_xfer_nxt;
    logic [CNT_W-1:0]      r_hdr_cnt, w_hdr_cnt_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic [LEN_W-1:0]      r_len, w_len_nxt;
    logic [7:0]            r_pat, w_pat_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [DATA_W-1:0]     r_buf, w_buf_nxt;
    logic [BEAT_BYTES-1:0] r_col_mask, w_col_mask_nxt;
    logic                  r_rd_loaded, w_rd_loaded_nxt;
    logic [DATA_W-1:0]     r_cmt_data, w_cmt_data_nxt;
    logic [BEAT_BYTES-1:0] r_cmt_mask, w_cmt_mask_nxt;
    logic [ADDR_W-1:0]     r_cmt_addr, w_cmt_addr_nxt;
    logic                  r_cmt_pend, w_cmt_pend_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic                  r_spi_pend, w_spi_pend_nxt;
    logic                  r_spi_done, w_spi_done_nxt;
    logic                  r_txd_strobe, w_txd_strobe_nxt;
    logic [7:0]            r_txd_data, w_txd_data_nxt;
    sdram_cmd_e            r_sdram_cmd, w_sdram_cmd_nxt;
    logic [ADDR_W+1:0]     r_sdram_addr, w_sdram_addr_nxt;
    logic [DATA_W-1:0]     r_wdata, w_wdata_nxt;
    logic [BEAT_BYTES-1:0] r_wmask, w_wmask_nxt;

    logic                  w_spi_rise;
    logic                  w_busy;
    logic                  w_wr_issue;
    logic                  w_collect;
    logic [CNT_W-1:0]      w_hdr_last;
    logic [DATA_W-1:0]     w_beat_data;
    logic [BEAT_BYTES-1:0] w_beat_mask;

    edge_sync u_spi_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (spi_req),
        .o_rise  (w_spi_rise)
    );

    // A command just issued still counts as busy for the following cycle.
    assign w_busy = (r_sdram_cmd != CMD_NOP) || sdram_cmd_busy;

    always_comb begin
        w_state_nxt      = r_state;
        w_xfer_nxt       = r_xfer;
        w_hdr_cnt_nxt    = r_hdr_cnt;
        w_addr_nxt       = r_addr;
        w_len_nxt        = r_len;
        w_pat_nxt        = r_pat;
        w_idx_nxt        = r_idx;
        w_buf_nxt        = r_buf;
        w_col_mask_nxt   = r_col_mask;
        w_rd_loaded_nxt  = r_rd_loaded;
        w_cmt_data_nxt   = r_cmt_data;
        w_cmt_mask_nxt   = r_cmt_mask;
        w_cmt_addr_nxt   = r_cmt_addr;
        w_cmt_pend_nxt   = r_cmt_pend;
        w_overrun_nxt    = r_overrun;
        w_spi_pend_nxt   = r_spi_pend | w_spi_rise;
        w_spi_done_nxt   = r_spi_done;
        w_txd_strobe_nxt = 1'b0;
        w_txd_data_nxt   = r_txd_data;
        w_sdram_cmd_nxt  = CMD_NOP;
        w_sdram_addr_nxt = r_sdram_addr;
        w_wdata_nxt      = r_wdata;
        w_wmask_nxt      = r_wmask;
        w_wr_issue       = 1'b0;
        w_collect        = 1'b0;
        w_hdr_last       = CNT_W'(ABYTES + 1) + ((r_xfer == XFER_FILL) ? CNT_W'(1) : CNT_W'(0));
        w_beat_data      = r_buf;
        w_beat_mask      = r_col_mask;

        unique case (r_state)
            ST_IDLE: begin
                // Pending erase wins; a byte arriving in the same cycle is lost.
                if (r_spi_pend) begin
                    w_spi_pend_nxt = w_spi_rise;
                    w_spi_done_nxt = (spi_len == '0);
                    w_addr_nxt     = spi_addr;
                    w_len_nxt      = spi_len;
                    w_state_nxt    = (spi_len == '0) ? ST_IDLE : ST_SPI_ACT;
                end else if (rxd_strobe && !spi_active) begin
                    w_hdr_cnt_nxt = '0;
                    w_addr_nxt    = '0;
                    w_len_nxt     = '0;
                    unique case (rxd_data)
                        OP_VERSION: begin
                            w_xfer_nxt  = XFER_VER;
                            w_state_nxt = ST_ACK;
                        end
                        OP_READ: begin
                            w_xfer_nxt  = XFER_READ;
                            w_state_nxt = ST_HDR;
                        end
                        OP_WRITE: begin
                            w_xfer_nxt  = XFER_WRITE;
                            w_state_nxt = ST_HDR;
                        end
                        OP_FILL: begin
                            w_xfer_nxt  = XFER_FILL;
                            w_state_nxt = ST_HDR;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HDR: begin
                if (rxd_strobe) begin
                    w_hdr_cnt_nxt = r_hdr_cnt + CNT_W'(1);
                    if (r_hdr_cnt < CNT_W'(ABYTES)) begin
                        w_addr_nxt = ADDR_W'({r_addr, rxd_data});
                    end else if (r_hdr_cnt < CNT_W'(ABYTES + 2)) begin
                        w_len_nxt = LEN_W'({r_len, rxd_data});
                    end else begin
                        w_pat_nxt = rxd_data;
                    end
                    if (r_hdr_cnt == w_hdr_last) begin
                        w_idx_nxt      = '0;
                        w_col_mask_nxt = '1;
                        unique case (r_xfer)
                            XFER_READ:  w_state_nxt = (w_len_nxt == '0) ? ST_IDLE : ST_RD_ACT;
                            XFER_WRITE: w_state_nxt = (w_len_nxt == '0) ? ST_ACK : ST_WR_COLLECT;
                            XFER_FILL:  w_state_nxt = (w_len_nxt == '0) ? ST_ACK : ST_FILL_ACT;
                            default:    w_state_nxt = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_RD_ACT: begin
                if (!w_busy) begin
                    w_sdram_cmd_nxt  = CMD_ACT;
                    w_sdram_addr_nxt = {r_addr, 2'b00};
                    w_state_nxt      = ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                if (!w_busy) begin
                    w_sdram_cmd_nxt  = CMD_READ;
                    w_sdram_addr_nxt = {r_addr, 2'b00};
                    w_rd_loaded_nxt  = 1'b0;
                    w_idx_nxt        = '0;
                    w_state_nxt      = ST_RD_SEND;
                end
            end
            ST_RD_SEND: begin
                if (!r_rd_loaded) begin
                    if (!w_busy) begin
                        w_buf_nxt       = sdram_rdata;
                        w_rd_loaded_nxt = 1'b1;
                    end
                end else if (txd_ready) begin
                    w_txd_strobe_nxt = 1'b1;
                    w_txd_data_nxt   = r_buf[{r_idx, 3'b000} +: 8];
                    w_idx_nxt        = r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_len_nxt   = r_len - LEN_W'(1);
                        w_state_nxt = (r_len == LEN_W'(1)) ? ST_IDLE : ST_RD_ACT;
                    end
                end
            end
            ST_WR_COLLECT: begin
                if (r_cmt_pend) begin
                    w_state_nxt = ST_WR_ACT;
                end else if (r_len == '0) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_WR_ACT: begin
                if (!w_busy) begin
                    w_sdram_cmd_nxt  = CMD_ACT;
                    w_sdram_addr_nxt = {r_cmt_addr, 2'b00};
                    w_state_nxt      = ST_WR_CMD;
                end
            end
            ST_WR_CMD: begin
                if (!w_busy) begin
                    w_sdram_cmd_nxt  = CMD_WRITE;
                    w_sdram_addr_nxt = {r_cmt_addr, 2'b00};
                    w_wdata_nxt      = r_cmt_data;
                    w_wmask_nxt      = r_cmt_mask;
                    w_cmt_pend_nxt   = 1'b0;
                    w_wr_issue       = 1'b1;
                    w_state_nxt      = ST_WR_COLLECT;
                end
            end
            ST_FILL_ACT, ST_SPI_ACT: begin
                if (!w_busy) begin
                    w_sdram_cmd_nxt  = CMD_ACT;
                    w_sdram_addr_nxt = {r_addr, 2'b00};
                    w_state_nxt      = (r_state == ST_FILL_ACT) ? ST_FILL_CMD : ST_SPI_CMD;
                end
            end
            ST_FILL_CMD, ST_SPI_CMD: begin
                if (!w_busy) begin
                    w_sdram_cmd_nxt  = CMD_WRITE;
                    w_sdram_addr_nxt = {r_addr, 2'b00};
                    w_wdata_nxt      = (r_state == ST_FILL_CMD) ? {BEAT_BYTES{r_pat}} : '1;
                    w_wmask_nxt      = '0;
                    w_addr_nxt       = r_addr + ADDR_W'(1);
                    w_len_nxt        = r_len - LEN_W'(1);
                    if (r_len != LEN_W'(1)) begin
                        w_state_nxt = (r_state == ST_FILL_CMD) ? ST_FILL_ACT : ST_SPI_ACT;
                    end else if (r_state == ST_FILL_CMD) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_spi_done_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                if (txd_ready) begin
                    w_txd_strobe_nxt = 1'b1;
                    if (r_xfer == XFER_VER) begin
                        w_txd_data_nxt = VERSION;
                    end else begin
                        w_txd_data_nxt = r_overrun ? ACK_OVERRUN : ACK_OK;
                    end
                    w_overrun_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Write bytes keep streaming in while the previous beat is being committed.
        w_collect = (r_state inside {ST_WR_COLLECT, ST_WR_ACT, ST_WR_CMD}) && rxd_strobe && (r_len != '0);
        if (w_collect) begin
            w_beat_data[{r_idx, 3'b000} +: 8] = rxd_data;
            w_beat_mask[r_idx]                = 1'b0;
            w_buf_nxt                         = w_beat_data;
            w_col_mask_nxt                    = w_beat_mask;
            w_idx_nxt                         = r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
                w_col_mask_nxt = '1;
                w_addr_nxt     = r_addr + ADDR_W'(1);
                w_len_nxt      = r_len - LEN_W'(1);
                if (!r_cmt_pend || w_wr_issue) begin
                    w_cmt_data_nxt = w_beat_data;
                    w_cmt_mask_nxt = w_beat_mask;
                    w_cmt_addr_nxt = r_addr;
                    w_cmt_pend_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_xfer       <= XFER_VER;
            r_hdr_cnt    <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_pat        <= '0;
            r_idx        <= '0;
            r_buf        <= '0;
            r_col_mask   <= '1;
            r_rd_loaded  <= 1'b0;
            r_cmt_data   <= '0;
            r_cmt_mask   <= '1;
            r_cmt_addr   <= '0;
            r_cmt_pend   <= 1'b0;
            r_overrun    <= 1'b0;
            r_spi_pend   <= 1'b0;
            r_spi_done   <= 1'b0;
            r_txd_strobe <= 1'b0;
            r_txd_data   <= '0;
            r_sdram_cmd  <= CMD_NOP;
            r_sdram_addr <= '0;
            r_wdata      <= '0;
            r_wmask      <= '1;
        end else begin
            r_state      <= w_state_nxt;
            r_xfer       <= w_xfer_nxt;
            r_hdr_cnt    <= w_hdr_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_len        <= w_len_nxt;
            r_pat        <= w_pat_nxt;
            r_idx        <= w_idx_nxt;
            r_buf        <= w_buf_nxt;
            r_col_mask   <= w_col_mask_nxt;
            r_rd_loaded  <= w_rd_loaded_nxt;
            r_cmt_data   <= w_cmt_data_nxt;
            r_cmt_mask   <= w_cmt_mask_nxt;
            r_cmt_addr   <= w_cmt_addr_nxt;
            r_cmt_pend   <= w_cmt_pend_nxt;
            r_overrun    <= w_overrun_nxt;
            r_spi_pend   <= w_spi_pend_nxt;
            r_spi_done   <= w_spi_done_nxt;
            r_txd_strobe <= w_txd_strobe_nxt;
            r_txd_data   <= w_txd_data_nxt;
            r_sdram_cmd  <= w_sdram_cmd_nxt;
            r_sdram_addr <= w_sdram_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wmask      <= w_wmask_nxt;
        end
    end

    assign txd_strobe  = r_txd_strobe;
    assign txd_data    = r_txd_data;
    assign sdram_cmd   = r_sdram_cmd;
    assign sdram_addr  = r_sdram_addr;
    assign sdram_wdata = r_wdata;
    assign sdram_wmask = r_wmask;
    assign spi_done    = r_spi_done;

endmodule

// File: doc/sdram_host_bridge.md
SDRAM_HOST_BRIDGE -- requirements
Module: sdram_host_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, SDRAM beat-address width.
REQ-002 SHALL have parameter LEN_W, default 16, beat-count width.
REQ-003 SHALL have parameter BEAT_BYTES, default 8, bytes per SDRAM beat, power of two, 2..16.
REQ-004 SHALL have parameter VERSION, default 8'h02, reply to the version opcode.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock.
REQ-007 reset_n  in  1  async active-low reset.
REQ-008 rxd_strobe / rxd_data  in  1 / 8  UART byte received, single-cycle pulse.
REQ-009 txd_ready  in  1  UART transmitter can accept a byte.
REQ-010 txd_strobe / txd_data  out  1 / 8  byte to transmit, single-cycle pulse.
REQ-011 sdram_cmd  out  2  00 nop, 01 read, 10 write, 11 activate; held exactly one cycle.
REQ-012 sdram_addr  out  ADDR_W+2  {beat address, 2'b00}.
REQ-013 sdram_cmd_busy  in  1  controller busy.
REQ-014 sdram_rdata  in  BEAT_BYTES*8  read beat, valid when not busy after a read.
REQ-015 sdram_wdata / sdram_wmask  out  BEAT_BYTES*8 / BEAT_BYTES  write beat; mask bit 1 = lane untouched.
REQ-016 spi_active  in  1  SPI slave owns memory; UART commands are suppressed.
REQ-017 spi_req / spi_addr / spi_len  in  1 / ADDR_W / LEN_W  async erase request (level), start beat, beat count.
REQ-018 spi_done  out  1  erase complete, level.

Function
REQ-019 busy SHALL be (sdram_cmd != 0) || sdram_cmd_busy; SDRAM commands issue only when busy is 0.
REQ-020 Each beat SHALL be activate, then read or write, at the same address.
REQ-021 Opcodes: 0x30 version, 0x31 read, 0x32 write, 0x33 fill; other opcodes in IDLE are dropped.
REQ-022 Header after 0x31/0x32/0x33: ceil(ADDR_W/8) address bytes MSB-first, then 2 length bytes MSB-first (beats); 0x33 adds 1 pattern byte.
REQ-023 States: IDLE, HDR, RD_ACT, RD_CMD, RD_SEND, WR_COLLECT, WR_ACT, WR_CMD, FILL_ACT, FILL_CMD, ACK, SPI_ACT, SPI_CMD.
REQ-024 Read: each beat sends BEAT_BYTES bytes, lane 0 first, one byte per txd_ready cycle; next beat at address+1.
REQ-025 Write: byte k of a beat is stored in lane k with its mask bit cleared; a full beat moves to a commit register and collection restarts at once.
REQ-026 If a beat completes while the previous commit is pending, the new beat SHALL be dropped and a sticky overrun flag set.
REQ-027 Fill: every beat SHALL be written with the pattern replicated in all lanes, mask all zeros.
REQ-028 Write and fill end in ACK: send 0x01, or 0xEE if overrun is set; wait for txd_ready; clear overrun; return to IDLE.
REQ-029 Length 0: read completes with no output; write/fill go straight to ACK with no SDRAM access.
REQ-030 The beat address SHALL wrap modulo 2^ADDR_W.
REQ-031 txd_strobe SHALL be asserted only in a cycle where txd_ready was 1 in the previous cycle.
REQ-032 spi_req SHALL pass a 2-flop synchroniser; a rising edge latches a pending erase; a pending erase starts only from IDLE.
REQ-033 Erase SHALL write all-ones beats with mask 0 over spi_len beats from spi_addr; spi_done is set at the end and cleared when the next erase is accepted.
REQ-034 A pending erase SHALL have priority over an rxd byte in the same IDLE cycle; that byte is dropped.
REQ-035 rxd bytes received while spi_active=1 in IDLE, or in any erase state, SHALL be dropped.

Reset
REQ-036 On reset_n=0, all outputs SHALL go to 0 except sdram_wmask, which goes to all ones.
REQ-037 On reset_n=0, state SHALL go to IDLE and the overrun, pending, and synchroniser flops SHALL clear, including mid-burst; no ACK is sent.

Structure
REQ-038 Package host_bridge_pkg SHALL hold the opcode constants, the sdram_cmd encodings, the ACK codes, and the state enum.
REQ-039 A sub-module edge_sync (2-flop synchroniser plus rising-edge pulse) SHALL be used for spi_req.

Verification
REQ-040 0x30 -> exactly one txd byte 0x02.
REQ-041 Write 0x32 addr 0x000010 len 0x0002, 16 bytes 0x00..0x0F, then read back the same range -> 2x(ACT, WR), ACK 0x01; readback returns 0x00..0x0F.
REQ-042 Fill 0x33 addr 0x3FFFFF len 2 pattern 0xA5 -> writes beats 0x3FFFFF and 0x000000 (wrap), data all 0xA5, mask 0, ACK 0x01.
REQ-043 Write of 2 beats with sdram_cmd_busy held high until the second beat is collected -> second beat dropped, ACK 0xEE.
REQ-044 spi_req rises during a 4-beat read -> read finishes; erase then writes spi_len beats of all-ones; spi_done=1.
REQ-045 reset_n pulsed low mid-read -> outputs at reset values in the same cycle, no further txd bytes, next 0x30 answered.
